// File: rtl/aq_djpeg_frame_seq_if.sv
// Control/status bundle between the register block, the JPEG decoder core
// and the frame sequencer.
interface aq_djpeg_frame_seq_if;
    logic        START;
    logic        ABORT;
    logic        IRQ_CLEAR;
    logic        DEC_IDLE;
    logic        DEC_PROG;
    logic        IN_HS;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        OUT_LAST;
    logic [15:0] WIDTH;
    logic [15:0] HEIGHT;
    logic        DEC_RESETN;
    logic        IN_GATE;
    logic        BUSY;
    logic        DONE;
    logic        IRQ;
    logic [2:0]  ERR_CODE;
    logic [31:0] PIXEL_COUNT;
    logic [15:0] FRAME_COUNT;

    modport slave (
        input  START, ABORT, IRQ_CLEAR, DEC_IDLE, DEC_PROG, IN_HS,
               OUT_VALID, OUT_READY, OUT_LAST, WIDTH, HEIGHT,
        output DEC_RESETN, IN_GATE, BUSY, DONE, IRQ, ERR_CODE,
               PIXEL_COUNT, FRAME_COUNT
    );

    modport master (
        output START, ABORT, IRQ_CLEAR, DEC_IDLE, DEC_PROG, IN_HS,
               OUT_VALID, OUT_READY, OUT_LAST, WIDTH, HEIGHT,
        input  DEC_RESETN, IN_GATE, BUSY, DONE, IRQ, ERR_CODE,
               PIXEL_COUNT, FRAME_COUNT
    );
endinterface

// File: rtl/aq_djpeg_frame_seq.sv
// Frame-level sequencer for the JPEG decoder: resets the core, gates input,
// counts output pixels, runs a watchdog and raises a sticky IRQ on done/error.
module aq_djpeg_frame_seq #(
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned TIMEOUT_W  = 24
) (
    input logic                 ACLK,
    input logic                 ARESETN,
    aq_djpeg_frame_seq_if.slave bus
);
    localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] WD_PRE = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_WAIT_BUSY, S_RUN, S_DRAIN, S_DONE, S_ERR
    } state_t;

    state_t               state_q, state_d;
    logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic [31:0]          pix_q, pix_d;
    logic [15:0]          frame_cnt_q, frame_d;
    logic [2:0]           err_code_q, err_code_d;
    logic                 irq_q, irq_d;
    logic                 dec_resetn_q, in_gate_q, busy_q, done_q;
    logic [2:0]           cause;
    logic                 out_hs, active, timeout, abort_ok;
    logic [31:0]          frame_px;

    assign out_hs   = bus.OUT_VALID & bus.OUT_READY;
    assign active   = (state_q == S_WAIT_BUSY) || (state_q == S_RUN) || (state_q == S_DRAIN);
    // Fires on the idle cycle that would carry the counter to all-ones.
    assign timeout  = active && !bus.IN_HS && !out_hs && (wd_q == WD_PRE);
    assign abort_ok = bus.ABORT && (state_q != S_IDLE) && (state_q != S_ERR);
    assign frame_px = 32'(bus.WIDTH) * 32'(bus.HEIGHT);

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        pix_d      = pix_q;
        frame_d    = frame_cnt_q;
        irq_d      = irq_q;
        err_code_d = err_code_q;
        cause      = 3'd0;

        case (state_q)
            S_IDLE: begin
                if (bus.START && !bus.ABORT) begin
                    state_d   = S_RESET;
                    rst_cnt_d = '0;
                    pix_d     = '0;
                end
            end
            S_RESET: begin
                if (rst_cnt_q == RST_LAST) state_d = S_WAIT_BUSY;
                else rst_cnt_d = rst_cnt_q + RCW'(1);
            end
            S_WAIT_BUSY: if (!bus.DEC_IDLE) state_d = S_RUN;
            S_RUN: begin
                if (out_hs && pix_q != '1) pix_d = pix_q + 32'd1;
                if (bus.DEC_PROG) cause = 3'd4;
                else if (out_hs && bus.OUT_LAST) begin
                    if (pix_q + 32'd1 == frame_px) state_d = S_DRAIN;
                    else cause = 3'd2;
                end
            end
            S_DRAIN: if (bus.DEC_IDLE) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // Error priority: abort > progressive > size > timeout.
        if (timeout && cause == 3'd0) cause = 3'd1;
        if (abort_ok) cause = 3'd3;
        if (cause != 3'd0) state_d = S_ERR;

        if (state_d == S_DONE) frame_d = frame_cnt_q + 16'd1;

        // A same-cycle set beats IRQ_CLEAR and keeps the new code.
        if (state_d == S_DONE || state_d == S_ERR) begin
            irq_d = 1'b1;
            if (state_d == S_ERR) err_code_d = cause;
        end else if (bus.IRQ_CLEAR) begin
            irq_d      = 1'b0;
            err_code_d = '0;
        end

        wd_d = (active && state_d == state_q && !bus.IN_HS && !out_hs)
             ? wd_q + TIMEOUT_W'(1) : '0;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= S_IDLE;
            rst_cnt_q    <= '0;
            wd_q         <= '0;
            pix_q        <= '0;
            frame_cnt_q  <= '0;
            err_code_q   <= '0;
            irq_q        <= 1'b0;
            dec_resetn_q <= 1'b0;
            in_gate_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            wd_q         <= wd_d;
            pix_q        <= pix_d;
            frame_cnt_q  <= frame_d;
            err_code_q   <= err_code_d;
            irq_q        <= irq_d;
            dec_resetn_q <= !((state_d == S_RESET) || (state_d == S_ERR));
            in_gate_q    <= (state_d == S_WAIT_BUSY) || (state_d == S_RUN);
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_DONE);
        end
    end

    assign bus.DEC_RESETN  = dec_resetn_q;
    assign bus.IN_GATE     = in_gate_q;
    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign bus.IRQ         = irq_q;
    assign bus.ERR_CODE    = err_code_q;
    assign bus.PIXEL_COUNT = pix_q;
    assign bus.FRAME_COUNT = frame_cnt_q;
endmodule
